// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: execute/LSU result inputs and register-file write port of the writeback arbiter.
interface wb_arbiter_if #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2
);
    logic                          alu_valid;
    logic [4:0]                    alu_rd;
    logic [XLEN-1:0]               alu_wdata;
    logic                          lsu_valid;
    logic                          lsu_ready;
    logic [4:0]                    lsu_rd;
    logic [XLEN-1:0]               lsu_wdata;
    logic                          rf_we;
    logic [4:0]                    rf_waddr;
    logic [XLEN-1:0]               rf_wdata;
    logic [$clog2(FIFO_DEPTH):0]   lsu_pending;

    modport master (
        output alu_valid, alu_rd, alu_wdata, lsu_valid, lsu_rd, lsu_wdata,
        input  lsu_ready, rf_we, rf_waddr, rf_wdata, lsu_pending
    );
    modport slave (
        input  alu_valid, alu_rd, alu_wdata, lsu_valid, lsu_rd, lsu_wdata,
        output lsu_ready, rf_we, rf_waddr, rf_wdata, lsu_pending
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and buffered LSU results onto one registered register-file write port.
// Optional WB_RETIRE_CNT_EN adds a 64-bit retired-slot counter port.
module wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            fire, has_entry, sel_fifo, sel_direct, sel_valid, push, pop;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        has_entry     = count != '0;
        bus.lsu_ready = rst_n && (count != CW'(FIFO_DEPTH));
        fire          = bus.lsu_valid && bus.lsu_ready;
        sel_fifo      = !bus.alu_valid && has_entry;
        sel_direct    = !bus.alu_valid && !has_entry && fire;
        sel_valid     = bus.alu_valid || sel_fifo || sel_direct;
        push          = fire && !sel_direct;
        pop           = sel_fifo;
        sel_rd        = bus.alu_valid ? bus.alu_rd : (has_entry ? fifo_rd[rd_ptr] : bus.lsu_rd);
        sel_data      = bus.alu_valid ? bus.alu_wdata : (has_entry ? fifo_data[rd_ptr] : bus.lsu_wdata);
    end

    assign bus.lsu_pending = count;

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.lsu_rd;
            fifo_data[wr_ptr] <= bus.lsu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            wr_ptr    <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count     <= count + CW'(push) - CW'(pop);
            bus.rf_we <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                bus.rf_waddr <= sel_rd;
                bus.rf_wdata <= sel_data;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) retire_cnt <= '0;
        else if (sel_valid) retire_cnt <= retire_cnt + 64'd1;
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random checks of wb_arbiter against a queue-based model.
module tb_wb_arbiter;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    logic [68:0] q[$];
    longint unsigned ret = 0;

    wb_arbiter_if #(.XLEN(64), .FIFO_DEPTH(DEPTH)) bus ();
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
    wb_arbiter #(.XLEN(64), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .retire_cnt(retire_cnt));
`else
    wb_arbiter #(.XLEN(64), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [63:0] ld);
        bus.alu_valid = av; bus.alu_rd = ar; bus.alu_wdata = ad;
        bus.lsu_valid = lv; bus.lsu_rd = lr; bus.lsu_wdata = ld;
    endtask

    // One clock of stimulus; the model picks ALU, then oldest buffered LSU, then a fresh LSU result.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [63:0] ld);
        logic exp_ready, fire, has, direct;
        logic [68:0] e;
        drive(av, ar, ad, lv, lr, ld);
        #1;
        exp_ready = q.size() < DEPTH;
        chk("lsu_ready", 64'(bus.lsu_ready), 64'(exp_ready));
        chk("lsu_pending", 64'(bus.lsu_pending), 64'(q.size()));
        fire = lv && exp_ready;
        has = 1'b1;
        direct = 1'b0;
        if (av) e = {ar, ad};
        else if (q.size() > 0) e = q.pop_front();
        else if (fire) begin e = {lr, ld}; direct = 1'b1; end
        else begin e = '0; has = 1'b0; end
        if (fire && !direct) q.push_back({lr, ld});
        if (has) ret++;
        @(posedge clk);
        #1;
        chk("rf_we", 64'(bus.rf_we), 64'(has && e[68:64] != 5'd0));
        if (has && e[68:64] != 5'd0) begin
            chk("rf_waddr", 64'(bus.rf_waddr), 64'(e[68:64]));
            chk("rf_wdata", bus.rf_wdata, e[63:0]);
        end
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, ret);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("ready_in_reset", 64'(bus.lsu_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("rst_wdata", bus.rf_wdata, 64'd0);
        chk("rst_pending", 64'(bus.lsu_pending), 64'd0);
        q.delete();
        ret = 0;
`ifdef WB_RETIRE_CNT_EN
        chk("rst_retire", retire_cnt, 64'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 64'(bus.lsu_ready), 64'd1);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0, 0, 0);
        // Lone LSU result takes the direct path.
        cycle(0, 0, 0, 1, 5, 64'h1234);
        chk("lone_waddr", 64'(bus.rf_waddr), 64'd5);
        chk("lone_wdata", bus.rf_wdata, 64'h1234);
        chk("lone_pending", 64'(bus.lsu_pending), 64'd0);
        // Collision: ALU first, LSU buffered then written.
        cycle(1, 3, 64'hAA, 1, 7, 64'hBB);
        chk("coll_pending", 64'(bus.lsu_pending), 64'd1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("coll_waddr", 64'(bus.rf_waddr), 64'd7);
        chk("coll_wdata", bus.rf_wdata, 64'hBB);
        // ALU streak while LSU offers every cycle: FIFO fills, then drains in order.
        for (int i = 0; i < 4; i++) cycle(1, 5'(10 + i), 64'(100 + i), 1, 5'(20 + i), 64'(200 + i));
        chk("streak_full", 64'(bus.lsu_pending), 64'd2);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 5'(24 + i), 64'(300 + i));
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
        // rd=0 consumes a slot without writing.
        cycle(1, 0, 64'hDEAD, 0, 0, 0);
        // Flush while two results are buffered.
        cycle(1, 1, 64'h11, 1, 2, 64'h22);
        cycle(1, 3, 64'h33, 1, 4, 64'h44);
        chk("pre_flush_pending", 64'(bus.lsu_pending), 64'd2);
        bus.alu_valid = 1'b0;
        do_reset();
        bus.lsu_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom});
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the 64-bit RV core: merges the single-cycle ALU result stream and the variable-latency LSU/multi-cycle result stream onto the one register-file write port (we/waddr/wdata). It sits between the execute/memory stages and the register file. It buffers LSU results in a small FIFO whenever the ALU holds the port, and it presents registered write-port outputs.

## Interface
- XLEN, 64, data width of results and write port
- FIFO_DEPTH, 2, LSU result buffer entries; power of two, ≥2

- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU result valid this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_wdata  in  XLEN  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  arbiter accepts LSU result this cycle
- lsu_rd  in  5  LSU destination register
- lsu_wdata  in  XLEN  LSU result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  write address (registered)
- rf_wdata  out  XLEN  write data (registered)
- lsu_pending  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- retire_cnt  out  64  results retired; present only with WB_RETIRE_CNT_EN

Reset is rst_n, synchronous, active-low; the clock is clk.

## Operation
- LSU handshake: transfer occurs when lsu_valid && lsu_ready.
  - lsu_ready = rst_n && (count != FIFO_DEPTH).
  - lsu_ready depends on occupancy only; it has no same-cycle pop lookahead.
- Slot selection, one per cycle, in fixed priority:
  1. ALU (alu_valid)
  2. FIFO head (count != 0)
  3. Direct LSU transfer (FIFO empty, handshake fires)
- A transferred LSU result that is not selected is pushed to the FIFO tail.
- An LSU result that is selected via the direct path bypasses the FIFO.
- LSU results retire in acceptance order. The FIFO is strictly in-order.
- ALU results are never stalled. The ALU can therefore starve the FIFO indefinitely, and the upstream pipeline owns forward-progress guarantees.
- Destination x0: the selected slot consumes the port, the next-cycle rf_we is 0, and the retire count still increments.
- Same-cycle ALU and LSU writes to the same rd write ALU first and LSU later. Resolving this WAW ordering is the issue logic's responsibility, not this block's.
- Simultaneous push and pop: occupancy is unchanged and the pointers both advance, with wrap-around modulo FIFO_DEPTH.

## Timing
- All write-port outputs are registered.
- Latency from a selected input to rf_we high is exactly 1 cycle.
- Best-case LSU latency is 1 cycle (direct path). Otherwise it is 1 + cycles spent in the FIFO.
- Reset values:
  - rf_we 0, rf_waddr 0, rf_wdata 0
  - FIFO empty, pointers 0, lsu_pending 0
  - lsu_ready 0 while rst_n is low
  - retire_cnt 0
- Reset mid-operation flushes the FIFO, and buffered results are discarded. rf_we is 0 in the cycle after reset is sampled.
- lsu_pending reflects registered occupancy. It updates one cycle after a push or pop.

## Configuration
- WB_RETIRE_CNT_EN defined:
  - adds the 64-bit retire_cnt register, incremented once per selected slot, including rd=0 slots
  - wraps at 2^64
  - the port is present
- WB_RETIRE_CNT_EN undefined:
  - the counter and the retire_cnt port are absent
  - all other behaviour is identical

## Test plan
- Reset then idle:
  - rf_we=0, lsu_pending=0, lsu_ready=1 on the first cycle after rst_n rises
  - rf_waddr=0, rf_wdata=0
- Lone LSU result (lsu_rd=5, wdata=0x1234) with alu_valid=0 → next cycle rf_we=1, waddr=5, wdata=0x1234, lsu_pending stays 0.
- Collision: ALU (rd=3, 0xAA) and LSU (rd=7, 0xBB) valid in cycle N → N+1 writes x3=0xAA; lsu_pending=1 at N+1; N+2 writes x7=0xBB.
- ALU valid for 4 consecutive cycles while LSU offers results every cycle (FIFO_DEPTH=2):
  - lsu_ready drops after 2 accepts
  - FIFO entries retire in order once the ALU idles
  - lsu_ready reasserts one cycle after the first pop
- Write to rd=0 (0xDEAD) → rf_we stays 0; with WB_RETIRE_CNT_EN, retire_cnt increments by 1.
- rst_n low for one cycle while lsu_pending=2 → FIFO flushed; lsu_pending=0 and rf_we=0 afterwards; no buffered result is written.
